// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FPU scheduler: op codes, flag bit positions,
// the result FIFO entry and the pipeline tag.
package fpu_sched_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011
    } fpu_op_e;

    // Bit positions inside the 8-bit flag vector
    localparam int FLAG_INF         = 7;
    localparam int FLAG_SNAN        = 6;
    localparam int FLAG_QNAN        = 5;
    localparam int FLAG_INE         = 4;
    localparam int FLAG_OVERFLOW    = 3;
    localparam int FLAG_UNDERFLOW   = 2;
    localparam int FLAG_ZERO        = 1;
    localparam int FLAG_DIV_BY_ZERO = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic [7:0]  flags;
    } res_entry_t;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/fpu_sched_fifo.sv
// Result FIFO for the FPU scheduler; entry type and depth are parameters.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fpu_sched_fifo
    import fpu_sched_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = res_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   wr_en,
    input  entry_t wr_data,
    input  logic   rd_en,
    output entry_t rd_data,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);

    entry_t      mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Write and read are independent, so a simultaneous push/pop keeps occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fpu_sched.sv
// Two-requester round-robin issue onto a shared fixed-latency FPU with a credited
// result FIFO. Define FPU_SCHED_STICKY_EN to accumulate popped flags in sticky_flags.
module fpu_sched
    import fpu_sched_pkg::*;
#(
    parameter int LAT        = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [5:0]  req_op,
    input  logic [3:0]  req_rmode,
    input  logic [63:0] req_opa,
    input  logic [63:0] req_opb,
    output logic [31:0] fpu_opa,
    output logic [31:0] fpu_opb,
    output logic [2:0]  fpu_op,
    output logic [1:0]  fpu_rmode,
    input  logic [31:0] fpu_out,
    input  logic [7:0]  fpu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic [7:0]  rsp_flags,
    output logic [7:0]  sticky_flags,
    input  logic        sticky_clr
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // Handshake: a request transfers on any cycle where req_valid[i] && req_ready[i];
    // a response transfers when rsp_valid && rsp_ready. Ready never waits on itself.

    logic [1:0] sync_q;
    logic       active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign active = sync_q[1];

    logic          rr_ptr;
    logic          gnt_any;
    logic          gnt_id;
    logic [CW-1:0] credits;
    logic          issue;
    logic          pop;

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = rr_ptr;
        if (req_valid[rr_ptr]) begin
            gnt_any = 1'b1;
            gnt_id  = rr_ptr;
        end else if (req_valid[!rr_ptr]) begin
            gnt_any = 1'b1;
            gnt_id  = !rr_ptr;
        end
    end

    assign issue     = active && gnt_any && (credits != '0);
    assign req_ready = issue ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= 1'b0;
            fpu_opa   <= '0;
            fpu_opb   <= '0;
            fpu_op    <= '0;
            fpu_rmode <= '0;
        end else if (issue) begin
            rr_ptr    <= !gnt_id;
            fpu_opa   <= gnt_id ? req_opa[63:32] : req_opa[31:0];
            fpu_opb   <= gnt_id ? req_opb[63:32] : req_opb[31:0];
            fpu_op    <= gnt_id ? req_op[5:3]    : req_op[2:0];
            fpu_rmode <= gnt_id ? req_rmode[3:2] : req_rmode[1:0];
        end
    end

    // Tag pipeline tracks which slots of the FPU hold a real operation.
    tag_t tag_q [LAT];
    tag_t tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0].valid <= issue;
            tag_q[0].id    <= issue & gnt_id;
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tail = tag_q[LAT-1];

    // Registered capture of the FPU result before it enters the FIFO.
    logic       res_valid_q;
    res_entry_t res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            res_valid_q <= tail.valid;
            if (tail.valid) begin
                res_q <= '{id: tail.id, data: fpu_out, flags: fpu_flags};
            end
        end
    end

    res_entry_t head;
    logic       fifo_empty;

    fpu_sched_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (res_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (res_valid_q),
        .wr_data (res_q),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_id    = head.id;
    assign rsp_data  = head.data;
    assign rsp_flags = head.flags;
    assign pop       = rsp_valid && rsp_ready;

    // A credit is taken at issue and only returned when the result leaves the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= CW'(FIFO_DEPTH);
        end else begin
            case ({issue, pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

`ifdef FPU_SCHED_STICKY_EN
    logic [7:0] sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else if (sticky_clr) begin
            sticky_q <= '0;
        end else if (pop) begin
            sticky_q <= sticky_q | rsp_flags;
        end
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_sticky_clr;

    assign unused_sticky_clr = sticky_clr;
    assign sticky_flags      = '0;
`endif

endmodule

// File: tb/tb_fpu_sched.sv
// Directed bench for fpu_sched: a behavioural FPU with fixed latency, a vector table
// for single operations, and hand-written sequences for arbitration, credits and reset.
module tb_fpu_sched;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;

    localparam logic [2:0] T_ADD = 3'b000;
    localparam logic [2:0] T_SUB = 3'b001;
    localparam logic [2:0] T_MUL = 3'b010;
    localparam logic [2:0] T_DIV = 3'b011;

`ifdef FPU_SCHED_STICKY_EN
    localparam logic [7:0] EXP_STICKY = 8'h20;
`else
    localparam logic [7:0] EXP_STICKY = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [5:0]  req_op = '0;
    logic [3:0]  req_rmode = '0;
    logic [63:0] req_opa = '0;
    logic [63:0] req_opb = '0;
    logic [31:0] fpu_opa;
    logic [31:0] fpu_opb;
    logic [2:0]  fpu_op;
    logic [1:0]  fpu_rmode;
    logic [31:0] fpu_out;
    logic [7:0]  fpu_flags;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_flags;
    logic [7:0]  sticky_flags;
    logic        sticky_clr = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_sched #(.LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_rmode    (req_rmode),
        .req_opa      (req_opa),
        .req_opb      (req_opb),
        .fpu_opa      (fpu_opa),
        .fpu_opb      (fpu_opb),
        .fpu_op       (fpu_op),
        .fpu_rmode    (fpu_rmode),
        .fpu_out      (fpu_out),
        .fpu_flags    (fpu_flags),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_flags    (rsp_flags),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr)
    );

    // Behavioural FPU: result appears LAT cycles after the issue cycle.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } fop_t;

    fop_t pipe [LAT-1];

    function automatic logic [39:0] fpu_model(input fop_t f);
        if (f.op == T_ADD && f.a == 32'h3F800000 && f.b == 32'h3F800000) return {32'h40000000, 8'h00};
        if (f.op == T_DIV && f.b == 32'h00000000) return {32'h7F800000, 8'h81};
        if (f.op == T_SUB && f.a == 32'h7F800000 && f.b == 32'h7F800000) return {32'h7FC00000, 8'h20};
        return {f.a ^ f.b ^ {29'd0, f.op}, 8'h00};
    endfunction

    always @(posedge clk) begin
        pipe[0] <= '{a: fpu_opa, b: fpu_opb, op: fpu_op};
        for (int i = 1; i < LAT-1; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    always_comb {fpu_out, fpu_flags} = fpu_model(pipe[LAT-2]);

    // Scoreboard for streamed results
    logic [31:0] exp_q[$];
    logic        sb_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_en && rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_pop", rsp_data, 32'hDEADDEAD);
            end else begin
                check("sb_order", rsp_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid[idx]          = 1'b1;
        req_op[idx*3 +: 3]      = op;
        req_rmode[idx*2 +: 2]   = 2'b00;
        req_opa[idx*32 +: 32]   = a;
        req_opb[idx*32 +: 32]   = b;
    endtask

    // Called one cycle after the issue edge; returns the cycle index where rsp_valid rises.
    task automatic wait_rsp(output int lat_out);
        lat_out = -1;
        for (int k = 1; k <= 30; k++) begin
            if (rsp_valid) begin
                lat_out = k;
                break;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    typedef struct {
        int          req;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic [7:0]  exp_flags;
    } vec_t;

    vec_t        vecs [5];
    int          lat;
    int          n;
    int          issued;
    logic [31:0] opa_s;
    logic        acc;

    initial begin
        vecs[0] = '{0, T_ADD, 32'h3F800000, 32'h3F800000, 32'h40000000, 8'h00};
        vecs[1] = '{1, T_DIV, 32'h3F800000, 32'h00000000, 32'h7F800000, 8'h81};
        vecs[2] = '{1, T_SUB, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 8'h20};
        vecs[3] = '{0, T_MUL, 32'h12345678, 32'h0F0F0F0F, 32'h1D3B5975, 8'h00};
        vecs[4] = '{1, T_ADD, 32'hAAAA0000, 32'h0000BBBB, 32'hAAAABBBB, 8'h00};

        // Reset state, with both requesters already asking
        set_req(0, T_ADD, 32'h11111111, 32'h0);
        set_req(1, T_ADD, 32'h22222222, 32'h0);
        #2;
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_fpu_opa", fpu_opa, 32'd0);
        check("rst_sticky", {24'd0, sticky_flags}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("sync_edge1_ready", {30'd0, req_ready}, 32'd0);
        tick();
        check("sync_edge2_ready", {30'd0, req_ready}, 32'd1);
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;

        // Single operations with the FIFO empty
        for (int v = 0; v < 5; v++) begin
            req_valid = '0;
            set_req(vecs[v].req, vecs[v].op, vecs[v].a, vecs[v].b);
            #1;
            check($sformatf("vec%0d_ready", v), {30'd0, req_ready}, (vecs[v].req == 1) ? 32'd2 : 32'd1);
            tick();
            req_valid = '0;
            #1;
            wait_rsp(lat);
            check($sformatf("vec%0d_latency", v), lat, LAT + 2);
            check($sformatf("vec%0d_data", v), rsp_data, vecs[v].exp_data);
            check($sformatf("vec%0d_id", v), {31'd0, rsp_id}, vecs[v].req);
            check($sformatf("vec%0d_flags", v), {24'd0, rsp_flags}, {24'd0, vecs[v].exp_flags});
            tick();
        end

        // Round robin with both requesters dividing by zero
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, T_DIV, 32'h3F800000, 32'h0);
        set_req(1, T_DIV, 32'h3F800000, 32'h0);
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("rr_grant%0d", c), {30'd0, req_ready}, (c % 2 == 0) ? 32'd1 : 32'd2);
            tick();
        end
        req_valid = '0;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            if (rsp_valid) begin
                check($sformatf("rr_rsp%0d_id", n), {31'd0, rsp_id}, n % 2);
                check($sformatf("rr_rsp%0d_flags", n), {24'd0, rsp_flags & 8'h81}, 32'h81);
                n++;
            end
            tick();
        end
        check("rr_rsp_count", n, 4);

        // Credit back-pressure with the consumer stalled
        rsp_ready = 1'b0;
        sb_en     = 1'b1;
        opa_s     = 32'h10000000;
        issued    = 0;
        set_req(0, T_ADD, opa_s, 32'h0);
        for (int c = 0; c < 40; c++) begin
            #1;
            acc = req_ready[0];
            if (acc) begin
                exp_q.push_back(opa_s);
                issued++;
            end
            tick();
            if (acc) begin
                opa_s = opa_s + 32'd1;
                set_req(0, T_ADD, opa_s, 32'h0);
            end
        end
        check("credit_issues", issued, DEPTH);
        #1;
        check("credit_ready_low", {30'd0, req_ready}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        issued = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            acc = req_ready[0];
            if (acc) begin
                exp_q.push_back(opa_s);
                issued++;
            end
            tick();
            if (acc) begin
                opa_s = opa_s + 32'd1;
                set_req(0, T_ADD, opa_s, 32'h0);
            end
        end
        check("credit_after_pop", issued, 1);
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 30; c++) tick();
        check("sb_drained", exp_q.size(), 0);
        sb_en = 1'b0;

        // Reset with three operations in flight
        set_req(0, T_ADD, 32'h50000000, 32'h0);
        n = 0;
        for (int c = 0; c < 10 && n < 3; c++) begin
            #1;
            if (req_ready[0]) n++;
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("inflight_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("inflight_rst_ready", {30'd0, req_ready}, 32'd0);
        check("inflight_rst_fpu_opa", fpu_opa, 32'd0);
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid) n++;
            tick();
        end
        check("no_stale_rsp", n, 0);
        rsp_ready = 1'b0;
        issued = 0;
        set_req(0, T_ADD, 32'h60000000, 32'h0);
        for (int c = 0; c < 40; c++) begin
            #1;
            if (req_ready[0]) issued++;
            tick();
        end
        check("credits_after_rst", issued, DEPTH);
        req_valid = '0;
        rsp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            if (rsp_valid) n++;
            tick();
        end
        check("drain_after_rst", n, DEPTH);

        // Sticky flags: invalid subtraction on requester 1
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        #1;
        check("sticky_cleared", {24'd0, sticky_flags}, 32'd0);
        rsp_ready = 1'b0;
        set_req(1, T_SUB, 32'h7F800000, 32'h7F800000);
        #1;
        tick();
        req_valid = '0;
        #1;
        wait_rsp(lat);
        check("qnan_latency", lat, LAT + 2);
        check("qnan_rsp_flag", {24'd0, rsp_flags & 8'h20}, 32'h20);
        check("qnan_sticky_before_pop", {24'd0, sticky_flags}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("qnan_sticky_after_pop", {24'd0, sticky_flags}, {24'd0, EXP_STICKY});
        tick();
        tick();
        check("qnan_sticky_holds", {24'd0, sticky_flags}, {24'd0, EXP_STICKY});
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        check("qnan_sticky_clr", {24'd0, sticky_flags}, 32'd0);

        // Clear and pop in the same cycle: clear wins, pop still happens
        set_req(1, T_SUB, 32'h7F800000, 32'h7F800000);
        #1;
        tick();
        req_valid = '0;
        #1;
        wait_rsp(lat);
        rsp_ready  = 1'b1;
        sticky_clr = 1'b1;
        tick();
        rsp_ready  = 1'b0;
        sticky_clr = 1'b0;
        check("clr_wins_sticky", {24'd0, sticky_flags}, 32'd0);
        check("clr_wins_popped", {31'd0, rsp_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got no end of test expected end before 200000ns");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_sched.md
FPU_SCHED -- requirements
Module: fpu_sched

Interface
REQ-001 Parameter LAT, default 4: fixed FPU pipeline latency in cycles, issue to result; legal range 2..10.
REQ-002 Parameter FIFO_DEPTH, default 8: result FIFO entries; power of two, minimum 2.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid / req_ready  in/out  2 / 2  per-requester valid/ready; index 0 and 1.
REQ-006 req_op / req_rmode  in  2x3 / 2x2  per-requester fpu_op (000 add, 001 sub, 010 mul, 011 div) and rounding mode.
REQ-007 req_opa / req_opb  in  2x32 / 2x32  per-requester IEEE-754 single operands.
REQ-008 fpu_opa / fpu_opb / fpu_op / fpu_rmode  out  32/32/3/2  operands driven to the shared FPU.
REQ-009 fpu_out / fpu_flags  in  32 / 8  FPU result and flags {inf,snan,qnan,ine,overflow,underflow,zero,div_by_zero}.
REQ-010 rsp_valid / rsp_ready  out/in  1 / 1  result handshake.
REQ-011 rsp_id / rsp_data / rsp_flags  out  1/32/8  requester index, result, flags.
REQ-012 sticky_flags / sticky_clr  out/in  8 / 1  accumulated flags (REQ-028).

Function
REQ-013 Grant SHALL be round-robin over requesters with req_valid high; the pointer moves past the granted index after each grant.
REQ-014 At most one grant per cycle; req_ready[i] SHALL be high only for the granted index, and only when a credit is available.
REQ-015 Credits = FIFO_DEPTH - (in-flight + FIFO occupancy); issue SHALL occur only when credits > 0, so the FIFO never overflows.
REQ-016 On handshake the operands, op and rmode SHALL be registered to fpu_* outputs the next cycle and held until the next issue.
REQ-017 A LAT-stage shift register SHALL carry {valid, id}; when its tail is valid, fpu_out and fpu_flags SHALL be written to the FIFO with that id.
REQ-018 FIFO head SHALL drive rsp_*; rsp_valid = FIFO not empty; pop on rsp_valid && rsp_ready.
REQ-019 Issue-to-rsp_valid latency SHALL be LAT+2 cycles when the FIFO is empty.
REQ-020 Write and pop in the same cycle SHALL both take effect, leaving occupancy unchanged, full or empty.
REQ-021 Issue and completion in the same cycle SHALL leave the credit count unchanged.
REQ-022 Results SHALL return in issue order; the FIFO pointers wrap modulo FIFO_DEPTH.
REQ-023 With no request valid, fpu_* outputs SHALL hold their last values and the pipeline tag SHALL shift in 0.

Reset
REQ-024 Asserting rst_n low SHALL immediately clear the tag pipeline, FIFO pointers, credits (to FIFO_DEPTH), RR pointer (to 0), sticky_flags, and fpu_* outputs (to 0).
REQ-025 While rst_n is low, req_ready and rsp_valid SHALL be 0.
REQ-026 Operations in flight at reset SHALL be discarded; FPU results arriving after deassertion without a valid tag SHALL be ignored.
REQ-027 Deassertion SHALL be synchronised internally; the first grant is possible on the second posedge after release.

Configuration
REQ-028 With FPU_SCHED_STICKY_EN defined, sticky_flags SHALL OR in rsp_flags on every pop and clear on sticky_clr; clear wins over a same-cycle pop.
REQ-029 Without FPU_SCHED_STICKY_EN, sticky_flags SHALL be tied to 0, sticky_clr is ignored, and no sticky register exists.

Structure
REQ-030 Package fpu_sched_pkg SHALL hold the op codes (ADD/SUB/MUL/DIV), the flag-bit index constants, and a typedef for the result entry {id, data, flags}.
REQ-031 The result FIFO SHALL be a sub-module, fpu_sched_fifo, parameterised by depth and entry type.

Verification
REQ-032 Req0 add 3F800000+3F800000, rsp_ready=1 -> rsp_data 40000000, id 0, flags 0, LAT+2 cycles after issue.
REQ-033 Both requesters valid for 4 cycles, each with div 3F800000/00000000 -> grants 0,1,0,1; each rsp_flags has div_by_zero and inf set.
REQ-034 rsp_ready=0, req0 streaming -> exactly FIFO_DEPTH issues, then req_ready=0; one pop -> exactly one further issue.
REQ-035 rst_n low with 3 ops in flight -> rsp_valid 0, no stale responses after release, credits equal FIFO_DEPTH.
REQ-036 Req1 sub 7F800000-7F800000, STICKY_EN defined -> rsp_flags qnan set, sticky qnan stays set after pop, clears on sticky_clr.
